// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4
//   Receive side of a 4-slot time-division-multiplexed link. It locks onto a
//   frame-sync marker and collects the slots a, b, c, d of each frame. The
//   complete frame is then presented on four registered channel outputs at
//   the same time, with a one-cycle frame strobe.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   din          slot data (WIDTH bits)
//   din_valid    din carries a slot this cycle
//   frame_sync   marks the current valid beat as slot a
//   a, b, c, d   registered channel outputs for slots 0..3
//   frame_valid  one-cycle pulse when a..d take a new frame
//   s0, s1       index of the next expected slot; {s0,s1} = 00/01/10/11 for a..d
//   locked       high while the receiver is frame-locked
//   sync_err     one-cycle pulse on a framing violation
module tdm_demux_1x4 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
  output logic             s0,
  output logic             s1,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state, state_n;
  logic [1:0]       cnt, cnt_n;
  logic [WIDTH-1:0] sa, sb, sc;
  logic [WIDTH-1:0] sa_n, sb_n, sc_n;
  logic             load;
  logic             err_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sa_n    = sa;
    sb_n    = sb;
    sc_n    = sc;
    load    = 1'b0;
    err_n   = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (frame_sync) begin
            sa_n    = din;
            cnt_n   = 2'd1;
            state_n = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // An early marker throws away the partial frame and starts a new
            // frame with this beat as its slot a.
            err_n = (cnt != 2'd0);
            sa_n  = din;
            cnt_n = 2'd1;
          end else begin
            case (cnt)
              2'd0: begin
                err_n   = 1'b1;
                state_n = HUNT;
                cnt_n   = 2'd0;
              end
              2'd1: begin
                sb_n  = din;
                cnt_n = 2'd2;
              end
              2'd2: begin
                sc_n  = din;
                cnt_n = 2'd3;
              end
              default: begin
                // Slot d goes straight to the output and is not shadowed.
                load  = 1'b1;
                cnt_n = 2'd0;
              end
            endcase
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      cnt         <= '0;
      sa          <= '0;
      sb          <= '0;
      sc          <= '0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sa          <= sa_n;
      sb          <= sb_n;
      sc          <= sc_n;
      frame_valid <= load;
      sync_err    <= err_n;
      if (load) begin
        a <= sa;
        b <= sb;
        c <= sc;
        d <= din;
      end
    end
  end

  assign s0     = cnt[1];
  assign s1     = cnt[0];
  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// tb_tdm_demux_1x4
//   Self-checking bench for tdm_demux_1x4 (WIDTH=4). Each table row is one
//   clock: the inputs to drive and the outputs expected after that edge.
//   Expected a..d are packed as 16'hABCD, with one nibble per channel.
module tb_tdm_demux_1x4;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic [W-1:0] a, b, c, d;
  logic         frame_valid, s0, s1, locked, sync_err;

  int unsigned nchecks = 0;
  int unsigned nerr    = 0;

  tdm_demux_1x4 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .frame_valid(frame_valid),
    .s0         (s0),
    .s1         (s1),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        v;
    logic        s;
    logic [3:0]  dn;
    logic [15:0] abcd;
    logic        fv;
    logic        se;
    logic        lk;
    logic [1:0]  cn;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic v, input logic s,
                              input logic [3:0] dn, input logic [15:0] abcd,
                              input logic fv, input logic se, input logic lk,
                              input logic [1:0] cn);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.dn = dn; t.abcd = abcd;
    t.fv = fv; t.se = se; t.lk = lk; t.cn = cn;
    return t;
  endfunction

  // Actual/expected layout: {a,b,c,d, frame_valid, sync_err, locked, s0, s1}
  task automatic check(input string nm, input int idx,
                       input logic [20:0] act, input logic [20:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got abcd=%h fv=%b se=%b lk=%b s=%b, want abcd=%h fv=%b se=%b lk=%b s=%b",
               nm, idx, act[20:5], act[4], act[3], act[2], act[1:0],
               exp[20:5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s, input logic [3:0] dn);
    rst        = r;
    din_valid  = v;
    frame_sync = s;
    din        = dn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_frame;
    logic [3:0]  dd [4];

    // reset, then lock on frame 1,0,1,0
    tbl.push_back(mk(1,0,0,4'h0, 16'h0000, 0,0,0, 2'd0));
    tbl.push_back(mk(1,1,1,4'h1, 16'h0000, 0,0,0, 2'd0));
    tbl.push_back(mk(0,1,1,4'h1, 16'h0000, 0,0,1, 2'd1));
    tbl.push_back(mk(0,1,0,4'h0, 16'h0000, 0,0,1, 2'd2));
    tbl.push_back(mk(0,1,0,4'h1, 16'h0000, 0,0,1, 2'd3));
    tbl.push_back(mk(0,1,0,4'h0, 16'h1010, 1,0,1, 2'd0));
    // gapped stream: same frame, 3 idle cycles between beats
    tbl.push_back(mk(0,1,1,4'h1, 16'h1010, 0,0,1, 2'd1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,1,4'hF, 16'h1010, 0,0,1, 2'd1));
    tbl.push_back(mk(0,1,0,4'h0, 16'h1010, 0,0,1, 2'd2));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,4'hF, 16'h1010, 0,0,1, 2'd2));
    tbl.push_back(mk(0,1,0,4'h1, 16'h1010, 0,0,1, 2'd3));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,1,4'hF, 16'h1010, 0,0,1, 2'd3));
    tbl.push_back(mk(0,1,0,4'h0, 16'h1010, 1,0,1, 2'd0));
    tbl.push_back(mk(0,0,0,4'h0, 16'h1010, 0,0,1, 2'd0));
    // early marker on the third beat
    tbl.push_back(mk(0,1,1,4'h1, 16'h1010, 0,0,1, 2'd1));
    tbl.push_back(mk(0,1,0,4'h1, 16'h1010, 0,0,1, 2'd2));
    tbl.push_back(mk(0,1,1,4'h0, 16'h1010, 0,1,1, 2'd1));
    tbl.push_back(mk(0,1,0,4'h1, 16'h1010, 0,0,1, 2'd2));
    tbl.push_back(mk(0,1,0,4'h1, 16'h1010, 0,0,1, 2'd3));
    tbl.push_back(mk(0,1,0,4'h0, 16'h0110, 1,0,1, 2'd0));
    // full frame 1,1,0,1, then a missing marker
    tbl.push_back(mk(0,1,1,4'h1, 16'h0110, 0,0,1, 2'd1));
    tbl.push_back(mk(0,1,0,4'h1, 16'h0110, 0,0,1, 2'd2));
    tbl.push_back(mk(0,1,0,4'h0, 16'h0110, 0,0,1, 2'd3));
    tbl.push_back(mk(0,1,0,4'h1, 16'h1101, 1,0,1, 2'd0));
    tbl.push_back(mk(0,1,0,4'h1, 16'h1101, 0,1,0, 2'd0));
    tbl.push_back(mk(0,1,0,4'h0, 16'h1101, 0,0,0, 2'd0));
    tbl.push_back(mk(0,1,0,4'h1, 16'h1101, 0,0,0, 2'd0));
    tbl.push_back(mk(0,0,1,4'h1, 16'h1101, 0,0,0, 2'd0));
    tbl.push_back(mk(0,1,1,4'h0, 16'h1101, 0,0,1, 2'd1));
    tbl.push_back(mk(0,1,0,4'h0, 16'h1101, 0,0,1, 2'd2));
    tbl.push_back(mk(0,1,0,4'h0, 16'h1101, 0,0,1, 2'd3));
    tbl.push_back(mk(0,1,0,4'h0, 16'h0000, 1,0,1, 2'd0));
    // reset mid-frame; rst wins over a valid beat, then frame 0,1,0,1
    tbl.push_back(mk(0,1,1,4'h1, 16'h0000, 0,0,1, 2'd1));
    tbl.push_back(mk(0,1,0,4'h1, 16'h0000, 0,0,1, 2'd2));
    tbl.push_back(mk(1,1,0,4'h1, 16'h0000, 0,0,0, 2'd0));
    tbl.push_back(mk(0,1,1,4'h0, 16'h0000, 0,0,1, 2'd1));
    tbl.push_back(mk(0,1,0,4'h1, 16'h0000, 0,0,1, 2'd2));
    tbl.push_back(mk(0,1,0,4'h0, 16'h0000, 0,0,1, 2'd3));
    tbl.push_back(mk(0,1,0,4'h1, 16'h0101, 1,0,1, 2'd0));
    tbl.push_back(mk(0,0,0,4'h0, 16'h0101, 0,0,1, 2'd0));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].dn);
      check("vec", i, {a, b, c, d, frame_valid, sync_err, locked, s0, s1},
            {tbl[i].abcd, tbl[i].fv, tbl[i].se, tbl[i].lk, tbl[i].cn});
    end

    // sustained throughput: 8 back-to-back frames of random data
    exp_frame = 16'h0101;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 4; k++) dd[k] = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) begin
        logic [1:0] ncnt;
        ncnt = 2'(k + 1);
        step(1'b0, 1'b1, (k == 0), dd[k]);
        if (k == 3) exp_frame = {dd[0], dd[1], dd[2], dd[3]};
        check("burst", f * 4 + k, {a, b, c, d, frame_valid, sync_err, locked, s0, s1},
              {exp_frame, (k == 3), 1'b0, 1'b1, ncnt});
      end
    end
    step(1'b0, 1'b0, 1'b0, 4'h0);
    check("burst_end", 0, {a, b, c, d, frame_valid, sync_err, locked, s0, s1},
          {exp_frame, 1'b0, 1'b0, 1'b1, 2'd0});

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
